noc_pkt_queue: RTL and testbench
================================

Name: noc_pkt_queue

Overview:
- Parametrised router input-port buffer: FIFO storage plus packet tracker, replacing the fixed 16-bit × 5-entry queue and its hard-wired 5-flit pop-count FSM.
- Decodes the destination field of each header flit and drives a one-hot output-port request.
- Holds that request (wormhole lock) until the packet's tail flit is popped.
- Sits between the link input and the switch allocator in each router port.

Parameters:
- DATA_W, 16, flit width in bits.
- DEPTH, 5, FIFO entries; any value ≥2, power of two not required.
- PKT_LEN, 5, flits per packet including header; ≥1.
- NPORTS, 5, router output ports; width of req_o.
- DEST_LSB, 13, LSB of destination field in header flit; field width DW = $clog2(NPORTS).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- valid_i  in  1  push request; flit written when valid_i && ready_o.
- data_i  in  DATA_W  flit in.
- ready_o  out  1  not full.
- pop_i  in  1  allocator grant/pop of head flit.
- data_o  out  DATA_W  head flit; first-word-fall-through; 0 when empty.
- empty_o  out  1  FIFO empty.
- count_o  out  $clog2(DEPTH+1)  occupancy.
- req_o  out  NPORTS  one-hot request for current packet's destination.
- tail_o  out  1  head flit is last flit of current packet (state ROUTE/BODY, cnt==PKT_LEN-1, !empty).

Behaviour:
- Reset (rst=0, async): pointers=0, count_o=0, empty_o=1, ready_o=1, data_o=0, req_o=0, tail_o=0, state=IDLE, cnt=0, dest_q=0.
- Push: accepted iff valid_i && !full; rejected push leaves state unchanged. ready_o is based on current-cycle occupancy, so a push while full is rejected even with a simultaneous pop.
- Pop: effective iff pop_i && !empty && state!=IDLE; otherwise ignored (no pointer/count change).
- Push and effective pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap DEPTH-1 -> 0.
- Latency: flit pushed at edge t appears on data_o, empty_o=0 after t. Header req_o asserts after edge t+1.
- FSM:
  - IDLE: req_o=0. If !empty: latch dest_q = data_o[DEST_LSB +: DW], cnt=0, -> ROUTE.
  - ROUTE: req_o = onehot(dest_q) (0 if dest_q ≥ NPORTS). On effective pop: if PKT_LEN==1 -> IDLE, else cnt=1, -> BODY.
  - BODY: req_o held. Stays asserted when FIFO runs dry mid-packet (body flits in flight). Effective pop: cnt++. Pop when cnt==PKT_LEN-1: cnt=0, -> IDLE.
- Back-to-back packets: after tail pop, one IDLE cycle before next header's request. This bubble is required, not optional.
- Out-of-range destination: packet is still tracked and drained by pops; req_o=0 throughout.
- Reset mid-packet: immediate return to reset values; partial packet discarded.

Optional Feature:
- Macro: NOC_PKT_QUEUE_ERR_EN.
- Defined: adds port err_o, out, 3 bits, sticky, cleared only by reset.
  - bit0 overflow: valid_i while full.
  - bit1 underflow: pop_i while empty or in IDLE.
  - bit2 bad destination: dest ≥ NPORTS latched in IDLE.
- Undefined: port absent; the same events are silently ignored as above.

Test Plan:
- Reset, push 5 flits (header 16'h4000 = dest 2, then 16'h0001..0004), no pops -> count_o=5, ready_o=0, req_o=5'b00100 two cycles after first push, data_o=16'h4000.
- Pop 5 consecutive cycles -> data_o steps 4000,0001..0004; tail_o=1 only on the 5th; req_o=0 the cycle after the tail pop; empty_o=1.
- Header only (dest 4, 16'h8000), then 3 idle cycles -> req_o=5'b10000 held through the FIFO-empty gap. Then 4 body flits and 5 pops -> req_o clears after the 5th pop.
- Full FIFO, valid_i=1 with pop_i=1 -> pop accepted, push rejected, count_o 5->4. Empty FIFO, pop_i=1 -> no change; err_o[1]=1 when the macro is defined.
- Header 16'hE000 (dest 7, NPORTS=5) -> req_o stays 0, five pops drain the packet, err_o[2]=1 with the macro defined.
- Assert rst low mid-BODY (cnt=2) -> all outputs at reset values immediately, without waiting for a clk edge; next push starts a new packet in IDLE.

Source files
------------

// File: rtl/noc_pkt_queue_if.sv
// Link-side handshake and allocator-side signals of the router input-port packet queue.
// The err_o bundle exists only when NOC_PKT_QUEUE_ERR_EN is defined.
interface noc_pkt_queue_if #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 5,
   parameter int NPORTS = 5
);
   localparam int CW = $clog2(DEPTH + 1);

   logic              valid_i;
   logic [DATA_W-1:0] data_i;
   logic              ready_o;
   logic              pop_i;
   logic [DATA_W-1:0] data_o;
   logic              empty_o;
   logic [CW-1:0]     count_o;
   logic [NPORTS-1:0] req_o;
   logic              tail_o;
`ifdef NOC_PKT_QUEUE_ERR_EN
   logic [2:0]        err_o;

   modport master (
      output valid_i, data_i, pop_i,
      input  ready_o, data_o, empty_o, count_o, req_o, tail_o, err_o
   );
   modport slave (
      input  valid_i, data_i, pop_i,
      output ready_o, data_o, empty_o, count_o, req_o, tail_o, err_o
   );
`else
   modport master (
      output valid_i, data_i, pop_i,
      input  ready_o, data_o, empty_o, count_o, req_o, tail_o
   );
   modport slave (
      input  valid_i, data_i, pop_i,
      output ready_o, data_o, empty_o, count_o, req_o, tail_o
   );
`endif
endinterface

// File: rtl/noc_pkt_queue.sv
// Router input-port buffer: FWFT flit FIFO plus wormhole packet tracker driving a one-hot port request.
// Optional sticky error flags (overflow/underflow/bad destination) when NOC_PKT_QUEUE_ERR_EN is defined.
module noc_pkt_queue #(
   parameter int DATA_W   = 16,
   parameter int DEPTH    = 5,
   parameter int PKT_LEN  = 5,
   parameter int NPORTS   = 5,
   parameter int DEST_LSB = 13
) (
   input  logic             clk,
   input  logic             rst,
   noc_pkt_queue_if.slave   q
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int DW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam int NW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

   typedef enum logic [1:0] {IDLE, ROUTE, BODY} state_t;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic              full, empty, push, pop, last;
   logic [DATA_W-1:0] head;
   logic [DW-1:0]     dest_hdr;

   state_t            state, state_nxt;
   logic [NW-1:0]     cnt, cnt_nxt;
   logic [DW-1:0]     dest_q, dest_nxt;
   logic [NPORTS-1:0] req;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   // ready reflects this cycle's occupancy only; a pop does not make room for a same-cycle push
   assign push     = q.valid_i && !full;
   assign pop      = q.pop_i && !empty && (state != IDLE);
   assign head     = empty ? '0 : mem[rd_ptr];
   assign dest_hdr = head[DEST_LSB +: DW];
   assign last     = (cnt == NW'(PKT_LEN - 1));

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= q.data_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         dest_q <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         dest_q <= dest_nxt;
      end
   end

   // IDLE always costs one cycle between a tail pop and the next header's request
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      dest_nxt  = dest_q;
      case (state)
         IDLE: begin
            if (!empty) begin
               dest_nxt  = dest_hdr;
               cnt_nxt   = '0;
               state_nxt = ROUTE;
            end
         end
         ROUTE: begin
            if (pop) begin
               if (PKT_LEN == 1) begin
                  state_nxt = IDLE;
               end else begin
                  cnt_nxt   = NW'(1);
                  state_nxt = BODY;
               end
            end
         end
         BODY: begin
            if (pop) begin
               if (last) begin
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  cnt_nxt = cnt + NW'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // out-of-range destinations match no port, so the request stays low for the whole packet
   always_comb begin
      req = '0;
      if (state != IDLE) begin
         for (int p = 0; p < NPORTS; p++) req[p] = (dest_q == DW'(p));
      end
   end

   assign q.ready_o = !full;
   assign q.data_o  = head;
   assign q.empty_o = empty;
   assign q.count_o = count;
   assign q.req_o   = req;
   assign q.tail_o  = (state != IDLE) && last && !empty;

`ifdef NOC_PKT_QUEUE_ERR_EN
   logic [2:0] err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err <= '0;
      end else begin
         if (q.valid_i && full)                    err[0] <= 1'b1;
         if (q.pop_i && (empty || state == IDLE))  err[1] <= 1'b1;
         if (state == IDLE && !empty && int'(dest_hdr) >= NPORTS) err[2] <= 1'b1;
      end
   end

   assign q.err_o = err;
`endif

   a_count_range: assert property (@(posedge clk) disable iff (!rst) count <= CW'(DEPTH));
   a_req_onehot:  assert property (@(posedge clk) disable iff (!rst) $onehot0(req));

endmodule

// File: tb/tb_noc_pkt_queue.sv
// Directed self-checking bench for noc_pkt_queue with the default parameter set.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_noc_pkt_queue;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   noc_pkt_queue_if #(.DATA_W(16), .DEPTH(5), .NPORTS(5)) bus ();

   noc_pkt_queue #(
      .DATA_W(16), .DEPTH(5), .PKT_LEN(5), .NPORTS(5), .DEST_LSB(13)
   ) dut (
      .clk (clk),
      .rst (rst),
      .q   (bus)
   );

   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push1(input logic [15:0] d);
      bus.valid_i = 1'b1;
      bus.data_i  = d;
      cycle();
      bus.valid_i = 1'b0;
   endtask

   task automatic test_reset();
      bus.valid_i = 1'b0;
      bus.data_i  = '0;
      bus.pop_i   = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count_o); end
      checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", bus.empty_o); end
      checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.ready_o); end
      checks++; if (bus.data_o !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", bus.data_o); end
      checks++; if (bus.req_o !== 5'b00000) begin errors++; $display("FAIL reset_req: got %b expected 00000", bus.req_o); end
      checks++; if (bus.tail_o !== 1'b0) begin errors++; $display("FAIL reset_tail: got %b expected 0", bus.tail_o); end
`ifdef NOC_PKT_QUEUE_ERR_EN
      checks++; if (bus.err_o !== 3'b000) begin errors++; $display("FAIL reset_err: got %b expected 000", bus.err_o); end
`endif
      rst = 1'b1;
      cycle();
   endtask

   task automatic test_fill();
      bus.valid_i = 1'b1;
      bus.data_i  = 16'h4000;
      cycle();
      checks++; if (bus.data_o !== 16'h4000) begin errors++; $display("FAIL fill_fwft: got %h expected 4000", bus.data_o); end
      checks++; if (bus.empty_o !== 1'b0) begin errors++; $display("FAIL fill_empty: got %b expected 0", bus.empty_o); end
      checks++; if (bus.req_o !== 5'b00000) begin errors++; $display("FAIL fill_req_early: got %b expected 00000", bus.req_o); end
      bus.data_i = 16'h0001;
      cycle();
      checks++; if (bus.req_o !== 5'b00100) begin errors++; $display("FAIL fill_req: got %b expected 00100", bus.req_o); end
      for (int i = 2; i <= 4; i++) begin
         bus.data_i = 16'(i);
         cycle();
      end
      bus.valid_i = 1'b0;
      checks++; if (bus.count_o !== 3'd5) begin errors++; $display("FAIL fill_count: got %0d expected 5", bus.count_o); end
      checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b expected 0", bus.ready_o); end
      checks++; if (bus.data_o !== 16'h4000) begin errors++; $display("FAIL fill_head: got %h expected 4000", bus.data_o); end
      checks++; if (bus.tail_o !== 1'b0) begin errors++; $display("FAIL fill_tail: got %b expected 0", bus.tail_o); end
   endtask

   task automatic test_pop();
      logic [15:0] exp_d [5];
      exp_d[0] = 16'h4000; exp_d[1] = 16'h0001; exp_d[2] = 16'h0002;
      exp_d[3] = 16'h0003; exp_d[4] = 16'h0004;
      bus.pop_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (bus.data_o !== exp_d[i]) begin errors++; $display("FAIL pop_data[%0d]: got %h expected %h", i, bus.data_o, exp_d[i]); end
         checks++; if (bus.tail_o !== (i == 4)) begin errors++; $display("FAIL pop_tail[%0d]: got %b expected %b", i, bus.tail_o, (i == 4)); end
         checks++; if (bus.req_o !== 5'b00100) begin errors++; $display("FAIL pop_req[%0d]: got %b expected 00100", i, bus.req_o); end
         cycle();
      end
      bus.pop_i = 1'b0;
      checks++; if (bus.req_o !== 5'b00000) begin errors++; $display("FAIL pop_req_clear: got %b expected 00000", bus.req_o); end
      checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL pop_empty: got %b expected 1", bus.empty_o); end
      checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL pop_count: got %0d expected 0", bus.count_o); end
      checks++; if (bus.data_o !== 16'h0000) begin errors++; $display("FAIL pop_data_empty: got %h expected 0000", bus.data_o); end
   endtask

   task automatic test_header_gap();
      push1(16'h8000);
      cycle();
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.req_o !== 5'b10000) begin errors++; $display("FAIL gap_req_hdr[%0d]: got %b expected 10000", i, bus.req_o); end
         cycle();
      end
      bus.pop_i = 1'b1;
      cycle();
      bus.pop_i = 1'b0;
      checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL gap_empty: got %b expected 1", bus.empty_o); end
      checks++; if (bus.req_o !== 5'b10000) begin errors++; $display("FAIL gap_req_dry: got %b expected 10000", bus.req_o); end
      cycle();
      cycle();
      checks++; if (bus.req_o !== 5'b10000) begin errors++; $display("FAIL gap_req_hold: got %b expected 10000", bus.req_o); end
      checks++; if (bus.tail_o !== 1'b0) begin errors++; $display("FAIL gap_tail_dry: got %b expected 0", bus.tail_o); end
      for (int i = 1; i <= 4; i++) push1(16'(i));
      checks++; if (bus.count_o !== 3'd4) begin errors++; $display("FAIL gap_count: got %0d expected 4", bus.count_o); end
      bus.pop_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus.data_o !== 16'(i + 1)) begin errors++; $display("FAIL gap_data[%0d]: got %h expected %h", i, bus.data_o, 16'(i + 1)); end
         checks++; if (bus.tail_o !== (i == 3)) begin errors++; $display("FAIL gap_tail[%0d]: got %b expected %b", i, bus.tail_o, (i == 3)); end
         cycle();
      end
      bus.pop_i = 1'b0;
      checks++; if (bus.req_o !== 5'b00000) begin errors++; $display("FAIL gap_req_clear: got %b expected 00000", bus.req_o); end
      checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL gap_empty_end: got %b expected 1", bus.empty_o); end
   endtask

   task automatic test_full_push_pop();
      push1(16'h4000);
      for (int i = 1; i <= 4; i++) push1(16'(i));
      checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", bus.ready_o); end
      bus.valid_i = 1'b1;
      bus.data_i  = 16'h1234;
      bus.pop_i   = 1'b1;
      cycle();
      bus.valid_i = 1'b0;
      checks++; if (bus.count_o !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", bus.count_o); end
      checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL full_ready_after: got %b expected 1", bus.ready_o); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus.data_o !== 16'(i + 1)) begin errors++; $display("FAIL full_data[%0d]: got %h expected %h", i, bus.data_o, 16'(i + 1)); end
         cycle();
      end
      bus.pop_i = 1'b0;
      checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL full_drop: got empty=%b expected 1", bus.empty_o); end
      checks++; if (bus.req_o !== 5'b00000) begin errors++; $display("FAIL full_req_clear: got %b expected 00000", bus.req_o); end
   endtask

   task automatic test_empty_pop();
`ifdef NOC_PKT_QUEUE_ERR_EN
      checks++; if (bus.err_o !== 3'b001) begin errors++; $display("FAIL err_overflow: got %b expected 001", bus.err_o); end
`endif
      bus.pop_i = 1'b1;
      cycle();
      bus.pop_i = 1'b0;
      checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL epop_count: got %0d expected 0", bus.count_o); end
      checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL epop_empty: got %b expected 1", bus.empty_o); end
      checks++; if (bus.req_o !== 5'b00000) begin errors++; $display("FAIL epop_req: got %b expected 00000", bus.req_o); end
`ifdef NOC_PKT_QUEUE_ERR_EN
      checks++; if (bus.err_o !== 3'b011) begin errors++; $display("FAIL err_underflow: got %b expected 011", bus.err_o); end
`endif
      push1(16'h0040);
      checks++; if (bus.data_o !== 16'h0040) begin errors++; $display("FAIL epop_ptr: got %h expected 0040", bus.data_o); end
      for (int i = 1; i <= 4; i++) push1(16'(i));
      bus.pop_i = 1'b1;
      repeat (5) cycle();
      bus.pop_i = 1'b0;
      checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL epop_drain: got %b expected 1", bus.empty_o); end
   endtask

   task automatic test_bad_dest();
      push1(16'hE000);
      for (int i = 1; i <= 4; i++) begin
         checks++; if (bus.req_o !== 5'b00000) begin errors++; $display("FAIL bad_req_fill[%0d]: got %b expected 00000", i, bus.req_o); end
         push1(16'(i));
      end
      checks++; if (bus.count_o !== 3'd5) begin errors++; $display("FAIL bad_count: got %0d expected 5", bus.count_o); end
      bus.pop_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (bus.req_o !== 5'b00000) begin errors++; $display("FAIL bad_req_pop[%0d]: got %b expected 00000", i, bus.req_o); end
         checks++; if (bus.tail_o !== (i == 4)) begin errors++; $display("FAIL bad_tail[%0d]: got %b expected %b", i, bus.tail_o, (i == 4)); end
         cycle();
      end
      bus.pop_i = 1'b0;
      checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL bad_drain: got %b expected 1", bus.empty_o); end
`ifdef NOC_PKT_QUEUE_ERR_EN
      checks++; if (bus.err_o[2] !== 1'b1) begin errors++; $display("FAIL err_bad_dest: got %b expected 1", bus.err_o[2]); end
`endif
   endtask

   task automatic test_back_to_back();
      push1(16'h2000);
      for (int i = 1; i <= 4; i++) push1(16'(i));
      checks++; if (bus.req_o !== 5'b00010) begin errors++; $display("FAIL b2b_req_a: got %b expected 00010", bus.req_o); end
      bus.pop_i = 1'b1;
      cycle();
      bus.valid_i = 1'b1;
      bus.data_i  = 16'h6000;
      cycle();
      bus.valid_i = 1'b0;
      checks++; if (bus.count_o !== 3'd4) begin errors++; $display("FAIL b2b_count_pp: got %0d expected 4", bus.count_o); end
      repeat (3) cycle();
      bus.pop_i = 1'b0;
      checks++; if (bus.req_o !== 5'b00000) begin errors++; $display("FAIL b2b_bubble: got %b expected 00000", bus.req_o); end
      checks++; if (bus.data_o !== 16'h6000) begin errors++; $display("FAIL b2b_head_b: got %h expected 6000", bus.data_o); end
      checks++; if (bus.tail_o !== 1'b0) begin errors++; $display("FAIL b2b_tail_idle: got %b expected 0", bus.tail_o); end
      cycle();
      checks++; if (bus.req_o !== 5'b01000) begin errors++; $display("FAIL b2b_req_b: got %b expected 01000", bus.req_o); end
      push1(16'h0001);
      push1(16'h0002);
      bus.pop_i = 1'b1;
      repeat (2) cycle();
      bus.pop_i = 1'b0;
      checks++; if (bus.count_o !== 3'd1) begin errors++; $display("FAIL b2b_count_mid: got %0d expected 1", bus.count_o); end
      checks++; if (bus.data_o !== 16'h0002) begin errors++; $display("FAIL b2b_data_mid: got %h expected 0002", bus.data_o); end
   endtask

   task automatic test_reset_mid();
      #2 rst = 1'b0;
      #1;
      checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL mrst_count: got %0d expected 0", bus.count_o); end
      checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL mrst_empty: got %b expected 1", bus.empty_o); end
      checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL mrst_ready: got %b expected 1", bus.ready_o); end
      checks++; if (bus.data_o !== 16'h0000) begin errors++; $display("FAIL mrst_data: got %h expected 0000", bus.data_o); end
      checks++; if (bus.req_o !== 5'b00000) begin errors++; $display("FAIL mrst_req: got %b expected 00000", bus.req_o); end
      checks++; if (bus.tail_o !== 1'b0) begin errors++; $display("FAIL mrst_tail: got %b expected 0", bus.tail_o); end
`ifdef NOC_PKT_QUEUE_ERR_EN
      checks++; if (bus.err_o !== 3'b000) begin errors++; $display("FAIL mrst_err: got %b expected 000", bus.err_o); end
`endif
      @(negedge clk);
      rst = 1'b1;
      cycle();
      push1(16'h2000);
      checks++; if (bus.req_o !== 5'b00000) begin errors++; $display("FAIL mrst_new_idle: got %b expected 00000", bus.req_o); end
      checks++; if (bus.count_o !== 3'd1) begin errors++; $display("FAIL mrst_new_count: got %0d expected 1", bus.count_o); end
      cycle();
      checks++; if (bus.req_o !== 5'b00010) begin errors++; $display("FAIL mrst_new_req: got %b expected 00010", bus.req_o); end
      checks++; if (bus.tail_o !== 1'b0) begin errors++; $display("FAIL mrst_new_tail: got %b expected 0", bus.tail_o); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_pop();
      test_header_gap();
      test_full_push_pop();
      test_empty_pop();
      test_bad_dest();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
